// File: rtl/rep_range_responder.sv
// ---------------------------------------------------------------------------
// rep_range_responder
//
// Responder side of the transmiter/recevier request-acknowledge pair.  Every
// accepted request (en && transmiter at a posedge) produces a registered
// recevier burst that starts one cycle later.  The burst lasts rep_len cycles,
// clamped to the range [MIN_REP, MAX_REP].  A request that arrives during a
// burst restarts the countdown, so recevier stays high with no gap.
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst         synchronous active-high reset
//   en          request acceptance enable
//   transmiter  request input
//   rep_len     requested burst length, sampled with transmiter
//   recevier    registered acknowledge burst
//   busy        high while in BURST
//   burst_done  high during the final recevier-high cycle of a burst
//   burst_cnt   saturating count of bursts started from IDLE
//   retrig_cnt  saturating count of requests accepted while in BURST
//   chk_err     sticky protocol-check error flag
//
// Optional feature macro: RESP_CHECK_EN
//   When defined, compiles an embedded concurrent assertion and a shadow
//   scoreboard that drives chk_err.  When undefined, chk_err is tied to 0.
// ---------------------------------------------------------------------------
module rep_range_responder #(
  parameter int MIN_REP = 2,
  parameter int MAX_REP = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             transmiter,
  input  logic [2:0]       rep_len,
  output logic             recevier,
  output logic             busy,
  output logic             burst_done,
  output logic [CNT_W-1:0] burst_cnt,
  output logic [CNT_W-1:0] retrig_cnt,
  output logic             chk_err
);

  localparam int REM_W = (MAX_REP > 0) ? $clog2(MAX_REP + 1) : 1;

  localparam logic IDLE  = 1'b0;
  localparam logic BURST = 1'b1;

  logic             state;
  logic [REM_W-1:0] rem;
  logic             recv_q;
  logic             trig;
  logic [2:0]       len_eff;
  logic [REM_W-1:0] rem_load;

  assign trig = en & transmiter;

  // Clamp the requested length into the legal burst range.
  always_comb begin
    len_eff = rep_len;
    if (rep_len < 3'(MIN_REP))
      len_eff = 3'(MIN_REP);
    else if (rep_len > 3'(MAX_REP))
      len_eff = 3'(MAX_REP);
  end

  // rem counts the cycles still to come after the current one.
  assign rem_load = REM_W'(len_eff - 3'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rem        <= '0;
      recv_q     <= 1'b0;
      burst_cnt  <= '0;
      retrig_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trig) begin
            state  <= BURST;
            recv_q <= 1'b1;
            rem    <= rem_load;
            if (burst_cnt != {CNT_W{1'b1}})
              burst_cnt <= burst_cnt + 1'b1;
          end
        end
        BURST: begin
          // A retrigger wins over the end-of-burst check, so the final
          // cycle can be extended without recevier dropping.
          if (trig) begin
            rem <= rem_load;
            if (retrig_cnt != {CNT_W{1'b1}})
              retrig_cnt <= retrig_cnt + 1'b1;
          end else if (rem == '0) begin
            state  <= IDLE;
            recv_q <= 1'b0;
          end else begin
            rem <= rem - 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          recv_q <= 1'b0;
        end
      endcase
    end
  end

  assign recevier   = recv_q;
  assign busy       = (state == BURST);
  assign burst_done = (state == BURST) && (rem == '0);

`ifdef RESP_CHECK_EN
  // Shadow scoreboard: bit k of pend means recevier must be high k+1 samples
  // from now.  Each accepted trigger re-arms the next MIN_REP samples.
  logic [MIN_REP-1:0] pend;
  logic               chk_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= '0;
      chk_err_q <= 1'b0;
    end else begin
      if (pend[0] && !recevier)
        chk_err_q <= 1'b1;
      pend <= (pend >> 1) | (trig ? {MIN_REP{1'b1}} : {MIN_REP{1'b0}});
    end
  end

  assign chk_err = chk_err_q;

  resp_range_a: assert property (
    @(posedge clk) disable iff (rst)
      (en && transmiter) |-> ##1 recevier [*MIN_REP:MAX_REP]
  ) else $error("rep_range_responder: recevier burst too short at time %0t", $time);
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_rep_range_responder.sv
// ---------------------------------------------------------------------------
// tb_rep_range_responder
//
// Directed bench for rep_range_responder.  Every step drives the inputs,
// waits one posedge and samples the outputs 1 ns later.  Expected values are
// hand-computed per step.  The counters are built 4 bits wide so saturation
// is reachable in a short run.
// ---------------------------------------------------------------------------
module tb_rep_range_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       transmiter;
  logic [2:0] rep_len;
  logic       recevier;
  logic       busy;
  logic       burst_done;
  logic [3:0] burst_cnt;
  logic [3:0] retrig_cnt;
  logic       chk_err;

  int checks   = 0;
  int failures = 0;

  rep_range_responder #(
    .MIN_REP(2),
    .MAX_REP(3),
    .CNT_W  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .transmiter(transmiter),
    .rep_len   (rep_len),
    .recevier  (recevier),
    .busy      (busy),
    .burst_done(burst_done),
    .burst_cnt (burst_cnt),
    .retrig_cnt(retrig_cnt),
    .chk_err   (chk_err)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, clock them in, and settle past the edge.
  task automatic applyStimulus(input logic r, input logic e, input logic t,
                               input logic [2:0] l);
    rst        = r;
    en         = e;
    transmiter = t;
    rep_len    = l;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // busy is expected to mirror recevier in every normal scenario.
  task automatic checkAll(input string tag, input logic rec, input logic done,
                          input int bc, input int rc);
    checkOutput({tag, ".recevier"},   int'(recevier),   int'(rec));
    checkOutput({tag, ".busy"},       int'(busy),       int'(rec));
    checkOutput({tag, ".burst_done"}, int'(burst_done), int'(done));
    checkOutput({tag, ".burst_cnt"},  int'(burst_cnt),  bc);
    checkOutput({tag, ".retrig_cnt"}, int'(retrig_cnt), rc);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; transmiter = 1'b0; rep_len = 3'd0;

    // Reset state
    applyStimulus(1, 1, 1, 3);
    applyStimulus(1, 0, 0, 0);
    checkAll("reset", 0, 0, 0, 0);
    checkOutput("reset.chk_err", int'(chk_err), 0);

    // Single request, rep_len=2
    applyStimulus(0, 1, 1, 2); checkAll("len2.c2", 1, 0, 1, 0);
    applyStimulus(0, 1, 0, 0); checkAll("len2.c3", 1, 1, 1, 0);
    applyStimulus(0, 1, 0, 0); checkAll("len2.c4", 0, 0, 1, 0);

    // Single request, rep_len=3
    applyStimulus(0, 1, 1, 3); checkAll("len3.c2", 1, 0, 2, 0);
    applyStimulus(0, 1, 0, 0); checkAll("len3.c3", 1, 0, 2, 0);
    applyStimulus(0, 1, 0, 0); checkAll("len3.c4", 1, 1, 2, 0);
    applyStimulus(0, 1, 0, 0); checkAll("len3.c5", 0, 0, 2, 0);

    // Clamp low: rep_len=0 gives 2 cycles
    applyStimulus(0, 1, 1, 0); checkAll("clamp0.c2", 1, 0, 3, 0);
    applyStimulus(0, 1, 0, 0); checkAll("clamp0.c3", 1, 1, 3, 0);
    applyStimulus(0, 1, 0, 0); checkAll("clamp0.c4", 0, 0, 3, 0);

    // Clamp high: rep_len=7 gives 3 cycles
    applyStimulus(0, 1, 1, 7); checkAll("clamp7.c2", 1, 0, 4, 0);
    applyStimulus(0, 1, 0, 0); checkAll("clamp7.c3", 1, 0, 4, 0);
    applyStimulus(0, 1, 0, 0); checkAll("clamp7.c4", 1, 1, 4, 0);
    applyStimulus(0, 1, 0, 0); checkAll("clamp7.c5", 0, 0, 4, 0);

    // Retrigger, rep_len=3, requests at cycles 1 and 3 -> high 2..6
    applyStimulus(0, 1, 1, 3); checkAll("retrig.c2", 1, 0, 5, 0);
    applyStimulus(0, 1, 0, 3); checkAll("retrig.c3", 1, 0, 5, 0);
    applyStimulus(0, 1, 1, 3); checkAll("retrig.c4", 1, 0, 5, 1);
    applyStimulus(0, 1, 0, 3); checkAll("retrig.c5", 1, 0, 5, 1);
    applyStimulus(0, 1, 0, 3); checkAll("retrig.c6", 1, 1, 5, 1);
    applyStimulus(0, 1, 0, 3); checkAll("retrig.c7", 0, 0, 5, 1);

    // transmiter held cycles 1-4, rep_len=2 -> high 2..6
    applyStimulus(0, 1, 1, 2); checkAll("hold.c2", 1, 0, 6, 1);
    applyStimulus(0, 1, 1, 2); checkAll("hold.c3", 1, 0, 6, 2);
    applyStimulus(0, 1, 1, 2); checkAll("hold.c4", 1, 0, 6, 3);
    applyStimulus(0, 1, 1, 2); checkAll("hold.c5", 1, 0, 6, 4);
    applyStimulus(0, 1, 0, 2); checkAll("hold.c6", 1, 1, 6, 4);
    applyStimulus(0, 1, 0, 2); checkAll("hold.c7", 0, 0, 6, 4);

    // Retrigger sampled in the burst_done cycle extends without a gap
    applyStimulus(0, 1, 1, 2); checkAll("donetrig.a", 1, 0, 7, 4);
    applyStimulus(0, 1, 0, 2); checkAll("donetrig.b", 1, 1, 7, 4);
    applyStimulus(0, 1, 1, 2); checkAll("donetrig.c", 1, 0, 7, 5);
    applyStimulus(0, 1, 0, 2); checkAll("donetrig.d", 1, 1, 7, 5);
    applyStimulus(0, 1, 0, 2); checkAll("donetrig.e", 0, 0, 7, 5);

    // en dropped mid-burst: burst completes, requests ignored
    applyStimulus(0, 1, 1, 3); checkAll("enmid.a", 1, 0, 8, 5);
    applyStimulus(0, 0, 1, 3); checkAll("enmid.b", 1, 0, 8, 5);
    applyStimulus(0, 0, 1, 3); checkAll("enmid.c", 1, 1, 8, 5);
    applyStimulus(0, 0, 1, 3); checkAll("enmid.d", 0, 0, 8, 5);
    applyStimulus(0, 0, 1, 3); checkAll("enmid.e", 0, 0, 8, 5);

    // burst_cnt saturation: 10 more bursts from 8 stops at 15
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 1, 2);
      applyStimulus(0, 1, 0, 2);
      applyStimulus(0, 1, 0, 2);
    end
    checkAll("sat.burst", 0, 0, 15, 5);

    // retrig_cnt saturation: 1 start + 14 retriggers from 5 stops at 15
    for (int i = 0; i < 15; i++)
      applyStimulus(0, 1, 1, 2);
    checkAll("sat.retrig.busy", 1, 0, 15, 15);
    applyStimulus(0, 1, 0, 2);
    applyStimulus(0, 1, 0, 2);
    checkAll("sat.retrig.end", 0, 0, 15, 15);

    // en=0 request ignored, then reset mid-burst
    applyStimulus(1, 0, 0, 0); checkAll("enlow.rst",  0, 0, 0, 0);
    applyStimulus(0, 0, 1, 3); checkAll("enlow.c2",   0, 0, 0, 0);
    applyStimulus(0, 0, 0, 3); checkAll("enlow.c3",   0, 0, 0, 0);
    applyStimulus(0, 1, 1, 3); checkAll("enlow.c4",   1, 0, 1, 0);
    applyStimulus(0, 1, 0, 3); checkAll("enlow.c5",   1, 0, 1, 0);
    applyStimulus(1, 1, 0, 3); checkAll("midrst.c6",  0, 0, 0, 0);
    applyStimulus(0, 1, 0, 3); checkAll("midrst.c7",  0, 0, 0, 0);
    checkOutput("final.chk_err", int'(chk_err), 0);

`ifdef RESP_CHECK_EN
    // Drop recevier for one sample inside a burst; the checker must latch it
    applyStimulus(0, 1, 1, 2);
    force dut.recv_q = 1'b0;
    applyStimulus(0, 1, 0, 2);
    release dut.recv_q;
    checkOutput("chk.set", int'(chk_err), 1);
    applyStimulus(0, 1, 0, 2);
    applyStimulus(0, 1, 0, 2);
    checkOutput("chk.sticky", int'(chk_err), 1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("chk.cleared", int'(chk_err), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
